// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg: address windows, FSM states and slave select codes for the data-bus arbiter.
package dm_bus_arbiter_pkg;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_END   = 32'h0000_2fff;
    localparam logic [31:0] TC1_BASE = 32'h0000_7f00;
    localparam logic [31:0] TC1_END  = 32'h0000_7f0b;
    localparam logic [31:0] TC2_BASE = 32'h0000_7f10;
    localparam logic [31:0] TC2_END  = 32'h0000_7f1b;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP, S_ERR} state_t;
    typedef enum logic [1:0] {SEL_DM, SEL_TC1, SEL_TC2, SEL_NONE} sel_t;
endpackage

// File: rtl/dm_addr_decode.sv
// dm_addr_decode: combinational slave select and legality check for one bus access.
module dm_addr_decode
    import dm_bus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic        we,
    output sel_t        sel,
    output logic        err
);
    logic in_dm, in_tc1, in_tc2, is_tc, be_ok;

    // Offset compares keep every window test a full 32-bit unsigned range check.
    assign in_dm  = (addr - DM_BASE)  <= (DM_END  - DM_BASE);
    assign in_tc1 = (addr - TC1_BASE) <= (TC1_END - TC1_BASE);
    assign in_tc2 = (addr - TC2_BASE) <= (TC2_END - TC2_BASE);
    assign is_tc  = in_tc1 | in_tc2;
    assign be_ok  = be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    assign sel    = in_dm ? SEL_DM : in_tc1 ? SEL_TC1 : in_tc2 ? SEL_TC2 : SEL_NONE;
    assign err    = (sel == SEL_NONE) | ~be_ok | (is_tc & (be != 4'b1111)) | (is_tc & we & (addr[3:2] == 2'b10));
endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: round-robin two-port data-bus arbiter for DM and TC1/TC2 with wait states.
// Optional DM_BUS_PERF_EN adds saturating conflict and error counters.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int   WAIT_CYC = 1,
    parameter logic RR_INIT  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  tc_addr,
    output logic        tc1_we,
    output logic        tc2_we,
    output logic [31:0] tc_wdata,
    input  logic [31:0] tc1_rdata,
    input  logic [31:0] tc2_rdata
`ifdef DM_BUS_PERF_EN
    ,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_err
`endif
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_t      state;
    sel_t        sel_q, sel_d;
    logic        owner, last_owner, we_q, err_d;
    logic [31:0] addr_q, wdata_q, addr_m, wdata_m, rd;
    logic [3:0]  be_q, be_m, cnt;
    logic        any, both, pick, we_m, idle, first, resp, errs;

    assign any     = m0_req | m1_req;
    assign both    = m0_req & m1_req;
    assign pick    = both ? ~last_owner : m1_req;
    assign addr_m  = pick ? m1_addr : m0_addr;
    assign be_m    = pick ? m1_be : m0_be;
    assign we_m    = pick ? m1_we : m0_we;
    assign wdata_m = pick ? m1_wdata : m0_wdata;

    dm_addr_decode u_dec (
        .addr (addr_m),
        .be   (be_m),
        .we   (we_m),
        .sel  (sel_d),
        .err  (err_d)
    );

    assign idle   = state == S_IDLE;
    assign first  = (state == S_ACC) && (cnt == CNT_INIT);
    assign resp   = state == S_RESP;
    assign errs   = state == S_ERR;
    assign m0_gnt = idle & any & ~pick;
    assign m1_gnt = idle & any & pick;

    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign tc_wdata = wdata_q;
    assign tc_addr  = addr_q[3:2];
    assign dm_be    = (first && we_q && sel_q == SEL_DM) ? be_q : 4'b0000;
    assign tc1_we   = first & we_q & (sel_q == SEL_TC1);
    assign tc2_we   = first & we_q & (sel_q == SEL_TC2);

    assign rd = we_q ? 32'h0 : sel_q == SEL_DM ? dm_rdata : sel_q == SEL_TC1 ? tc1_rdata : sel_q == SEL_TC2 ? tc2_rdata : 32'h0;
    assign m0_rvalid = (resp | errs) & ~owner;
    assign m1_rvalid = (resp | errs) & owner;
    assign m0_err    = errs & ~owner;
    assign m1_err    = errs & owner;
    assign m0_rdata  = (resp & ~owner) ? rd : 32'h0;
    assign m1_rdata  = (resp & owner) ? rd : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= RR_INIT;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            we_q       <= 1'b0;
            sel_q      <= SEL_NONE;
            cnt        <= 4'h0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    owner   <= pick;
                    addr_q  <= addr_m;
                    wdata_q <= wdata_m;
                    be_q    <= be_m;
                    we_q    <= we_m;
                    sel_q   <= sel_d;
                    cnt     <= CNT_INIT;
                    state   <= err_d ? S_ERR : S_ACC;
                end
                S_ACC: if (cnt == 4'h0) state <= S_RESP; else cnt <= cnt - 4'h1;
                default: begin
                    last_owner <= owner;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DM_BUS_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_conflict <= 32'h0;
            perf_err      <= 32'h0;
        end else begin
            if (idle && both && perf_conflict != 32'hffff_ffff) perf_conflict <= perf_conflict + 32'h1;
            if (idle && any && err_d && perf_err != 32'hffff_ffff) perf_err <= perf_err + 32'h1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: randomized two-port traffic checked against a transaction-timing reference model.
module tb_dm_bus_arbiter;
    localparam int W = 3;

    logic        clk = 1'b0, reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, tc_wdata, tc1_rdata, tc2_rdata;
    logic [3:0]  dm_be;
    logic [1:0]  tc_addr;
    logic        tc1_we, tc2_we;
`ifdef DM_BUS_PERF_EN
    logic [31:0] perf_conflict, perf_err;
`endif

    always #5 clk = ~clk;

    dm_bus_arbiter #(.WAIT_CYC(W), .RR_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .tc_addr(tc_addr), .tc1_we(tc1_we), .tc2_we(tc2_we), .tc_wdata(tc_wdata),
        .tc1_rdata(tc1_rdata), .tc2_rdata(tc2_rdata)
`ifdef DM_BUS_PERF_EN
        , .perf_conflict(perf_conflict), .perf_err(perf_err)
`endif
    );

    int checks = 0, passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // requester agents
    logic        pend [2];
    logic        gseen [2];
    logic [31:0] pa [2], pd [2];
    logic        pw [2];
    logic [3:0]  pb [2];
    bit          no_new;

    // reference model
    int          t, free_at, strobe_t, resp_t, n_conf, n_err, m_reg;
    bit          last, m_own, m_we, m_err;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 11))
            0: return 32'h0000_0010;
            1: return 32'h0000_2ffc;
            2: return 32'h0000_3000;
            3: return 32'h0000_7f00;
            4: return 32'h0000_7f04;
            5: return 32'h0000_7f08;
            6: return 32'h0000_7f0c;
            7: return 32'h0000_7f14;
            8: return 32'h0000_7f18;
            9: return 32'h0000_7f1c;
            10: return 32'hffff_fffc;
            default: return $urandom & 32'h0000_3ffc;
        endcase
    endfunction

    function automatic int region(input logic [31:0] a);
        if (a <= 32'h2fff) return 0;
        if (a >= 32'h7f00 && a <= 32'h7f0b) return 1;
        if (a >= 32'h7f10 && a <= 32'h7f1b) return 2;
        return 3;
    endfunction

    function automatic bit bad(input logic [31:0] a, input logic [3:0] b, input bit w);
        int r = region(a);
        bit word = b == 4'hf;
        bit half = b == 4'h3 || b == 4'hc;
        bit one = $countones(b) == 1;
        logic [31:0] off = a - (r == 1 ? 32'h7f00 : 32'h7f10);
        if (r == 3 || !(word || half || one)) return 1;
        if (r != 0 && !word) return 1;
        if (r != 0 && w && (off >> 2) == 2) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        t = 0; free_at = 0; strobe_t = -1; resp_t = -1; last = 1; n_conf = 0; n_err = 0;
        pend[0] = 0; pend[1] = 0; gseen[0] = 0; gseen[1] = 0;
    endtask

    task automatic drive_ports();
        m0_req = pend[0]; m0_addr = pa[0]; m0_we = pw[0]; m0_be = pb[0]; m0_wdata = pd[0];
        m1_req = pend[1]; m1_addr = pa[1]; m1_we = pw[1]; m1_be = pb[1]; m1_wdata = pd[1];
    endtask

    task automatic step();
        bit r0 = m0_req, r1 = m1_req, p;
        logic eg0 = 0, eg1 = 0, erv0 = 0, erv1 = 0, ee0 = 0, ee1 = 0, et1 = 0, et2 = 0;
        logic [31:0] erd0 = 0, erd1 = 0, slv;
        logic [3:0] ebe = 0;
        if (t == strobe_t) begin
            check("dm_addr", dm_addr, m_addr);
            check("tc_addr", tc_addr, m_addr[3:2]);
            if (m_we) begin
                ebe = m_reg == 0 ? m_be : 4'h0;
                et1 = m_reg == 1;
                et2 = m_reg == 2;
                check("dm_wdata", dm_wdata, m_wd);
                check("tc_wdata", tc_wdata, m_wd);
            end
        end
        if (t == resp_t) begin
            slv = m_reg == 0 ? dm_rdata : m_reg == 1 ? tc1_rdata : tc2_rdata;
            slv = (m_err || m_we) ? 32'h0 : slv;
            if (m_own) begin erv1 = 1; ee1 = m_err; erd1 = slv; end
            else begin erv0 = 1; ee0 = m_err; erd0 = slv; end
            last = m_own;
        end
        if (t >= free_at && (r0 || r1)) begin
            p = (r0 && r1) ? !last : r1;
            if (r0 && r1) n_conf++;
            if (p) eg1 = 1; else eg0 = 1;
            gseen[p] = 1;
            m_own = p; m_addr = pa[p]; m_we = pw[p]; m_be = pb[p]; m_wd = pd[p];
            m_reg = region(m_addr);
            m_err = bad(m_addr, m_be, m_we);
            if (m_err) begin
                n_err++; strobe_t = -1; resp_t = t + 1; free_at = t + 2;
            end else begin
                strobe_t = t + 1; resp_t = t + W + 1; free_at = t + W + 2;
            end
        end
        check("m0_gnt", m0_gnt, eg0);
        check("m1_gnt", m1_gnt, eg1);
        check("m0_rvalid", m0_rvalid, erv0);
        check("m1_rvalid", m1_rvalid, erv1);
        check("m0_err", m0_err, ee0);
        check("m1_err", m1_err, ee1);
        check("m0_rdata", m0_rdata, erd0);
        check("m1_rdata", m1_rdata, erd1);
        check("dm_be", dm_be, ebe);
        check("tc1_we", tc1_we, et1);
        check("tc2_we", tc2_we, et2);
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                if (gseen[q]) pend[q] = 0;
                gseen[q] = 0;
                if (!pend[q] && !no_new && $urandom_range(0, 99) < 35) begin
                    pend[q] = 1;
                    pa[q] = pick_addr();
                    pw[q] = 1'($urandom_range(0, 1));
                    pb[q] = ($urandom_range(0, 3) != 0) ? 4'hf : 4'($urandom_range(0, 15));
                    pd[q] = $urandom;
                end else if (pend[q] && $urandom_range(0, 99) < 4) pend[q] = 0;
            end
            drive_ports();
            dm_rdata = $urandom; tc1_rdata = $urandom; tc2_rdata = $urandom;
            #1 step();
        end
    endtask

    initial begin
        reset = 1; no_new = 0;
        model_reset();
        for (int q = 0; q < 2; q++) begin pa[q] = 0; pd[q] = 0; pw[q] = 0; pb[q] = 0; end
        drive_ports();
        dm_rdata = 32'hdead_beef; tc1_rdata = 32'h1111_1111; tc2_rdata = 32'h2222_2222;
        repeat (3) @(negedge clk);
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m0_err", m0_err, 0);
        check("rst_m1_err", m1_err, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_dm_be", dm_be, 0);
        check("rst_tc1_we", tc1_we, 0);
        check("rst_tc2_we", tc2_we, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_dm_wdata", dm_wdata, 0);
        reset = 0;
        // first tie after reset must go to m0
        pend[0] = 1; pa[0] = 32'h10; pw[0] = 0; pb[0] = 4'hf; pd[0] = 0;
        pend[1] = 1; pa[1] = 32'h20; pw[1] = 0; pb[1] = 4'hf; pd[1] = 0;
        run(3000);
`ifdef DM_BUS_PERF_EN
        check("perf_conflict", perf_conflict, n_conf);
        check("perf_err", perf_err, n_err);
`endif
        no_new = 1; pend[0] = 0; pend[1] = 0;
        run(W + 3);
        @(negedge clk);
        pend[0] = 1; pa[0] = 32'h10; pw[0] = 1; pb[0] = 4'hf; pd[0] = 32'h5a5a_5a5a;
        drive_ports();
        #1 check("abort_gnt", m0_gnt, 1);
        @(negedge clk);
        pend[0] = 0;
        drive_ports();
        #1 check("abort_strobe", dm_be, 4'hf);
        reset = 1;
        #1 check("abort_be_rst", dm_be, 0);
        @(negedge clk);
        reset = 0;
        repeat (W + 3) begin
            @(negedge clk);
            #1;
            check("abort_m0_rvalid", m0_rvalid, 0);
            check("abort_m1_rvalid", m1_rvalid, 0);
            check("abort_dm_be", dm_be, 0);
        end
`ifdef DM_BUS_PERF_EN
        check("perf_conflict_rst", perf_conflict, 0);
        check("perf_err_rst", perf_err, 0);
`endif
        model_reset();
        no_new = 0;
        run(400);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Sequences and shares the data-side bus between two requesters: port m0 (CPU M stage) and port m1 (debug/DMA port).
- Targets are data memory (DM, 0x0000_0000–0x0000_2fff) and two timer register files: TC1 (0x0000_7f00–0x0000_7f0b) and TC2 (0x0000_7f10–0x0000_7f1b).
- Performs round-robin arbitration, address decode, per-access slave strobing with configurable wait states, and error responses for illegal accesses.
- Sits between the M stage and the DM/timer instances in the top-level bridge.

Parameters:
- WAIT_CYC, 1: extra cycles held in ACC before a response (models DM read latency); legal range 1–15.
- RR_INIT, 1: reset value of last_owner, so m0 wins the first tie.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 request; m0_addr/m0_be/m0_we/m0_wdata must stay stable until m0_gnt.
- m0_addr  in  32  byte address.
- m0_we  in  1  1 = store, 0 = load.
- m0_be  in  4  byte enables; 4'b1111 = word.
- m0_wdata  in  32  store data, already lane-aligned.
- m0_gnt  out  1  one-cycle pulse: request accepted.
- m0_rvalid  out  1  one-cycle pulse: response valid.
- m0_rdata  out  32  raw word read; 0 for stores and errors.
- m0_err  out  1  qualifies m0_rvalid: access refused.
- m1_req, m1_addr, m1_we, m1_be, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical to the m0 set.
- dm_addr  out  32  latched address to DM.
- dm_be  out  4  DM byte write strobes; nonzero only on the ACC first cycle of a store.
- dm_wdata  out  32  store data to DM.
- dm_rdata  in  32  DM read word, valid WAIT_CYC cycles after ACC entry.
- tc_addr  out  2  timer register index (addr[3:2]).
- tc1_we, tc2_we  out  1  timer write strobes.
- tc_wdata  out  32  store data to the timers.
- tc1_rdata, tc2_rdata  in  32  combinational timer read data.

Behaviour:
- Reset state: FSM in IDLE; every gnt/rvalid/err/we/be output is 0; rdata = 0; latched address/data = 0; last_owner = RR_INIT.
- Reset mid-access aborts the access: no response is issued and no strobe is given afterwards.
- FSM states: IDLE, ACC, RESP, ERR.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesters: grant the one that is not last_owner.
  - gnt is asserted combinationally in the same cycle. Owner, addr, we, be and wdata are latched at the edge.
  - Next state is ERR if decode fails, otherwise ACC.
- Decode failure is any of:
  - Address outside the three windows above.
  - be == 0, or be not one of 1111/0011/1100/0001/0010/0100/1000.
  - Timer access with be != 4'b1111.
  - Store to a timer offset 0x8 (count register is read-only).
- ACC:
  - Slave selected by the latched address.
  - Write strobe (dm_be = latched be, or tcN_we = 1) asserted only in the first ACC cycle.
  - A counter loads WAIT_CYC-1 and decrements each cycle; at 0, go to RESP.
  - Total ACC duration is WAIT_CYC cycles.
- RESP:
  - Owner's rvalid = 1 for one cycle, with rdata = the selected slave's read word (loads) or 0 (stores); err = 0.
  - last_owner <= owner; next state IDLE.
- ERR:
  - Owner's rvalid = 1 and err = 1 for one cycle; rdata = 0; no slave strobe.
  - last_owner <= owner; next state IDLE.
- No grants are issued outside IDLE. A request arriving during ACC/RESP/ERR waits.
- Back-to-back throughput: one access per WAIT_CYC+2 cycles.
- Non-owner outputs are always 0.
- Request dropped before gnt: no side effect.
- Simultaneous requests from both ports alternate strictly, giving no starvation.
- Address wrap: the decode compares full 32-bit values; 0xffff_fffc errors.

Optional Feature:
- Macro DM_BUS_PERF_EN.
- Defined:
  - Adds outputs perf_conflict[31:0] (counts IDLE cycles where both req = 1).
  - Adds perf_err[31:0] (counts ERR entries).
  - Both counters are reset to 0, saturate at 0xffff_ffff, and are cleared by reset only.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/const header holds:
  - Window bounds: DM_BASE, DM_END, TC1_BASE, TC1_END, TC2_BASE, TC2_END.
  - FSM state encodings: S_IDLE, S_ACC, S_RESP, S_ERR.
  - Slave select codes: SEL_DM, SEL_TC1, SEL_TC2, SEL_NONE.
- One sub-module, dm_addr_decode: purely combinational. Takes addr/be/we and returns sel and err; reused by the debug port checker.

Test Plan:
- m0 load 0x0000_0010 (be 1111), DM returns 0x1234_5678, WAIT_CYC=1 -> gnt at cycle 0, dm_be=0 throughout, m0_rvalid at cycle 2, rdata 0x1234_5678, err 0.
- m0 and m1 both request at the same cycle after reset -> m0 granted first, m1 granted in the IDLE cycle after m0's RESP; repeat -> alternation m0, m1, m0, m1.
- m1 store be=0011 wdata 0x0000_abcd to 0x0000_2ffc -> dm_be=0011 for exactly one cycle, m1_rvalid with rdata 0, err 0.
- m0 load to 0x0000_3000, store be=0001 to 0x0000_7f04, and store to 0x0000_7f18 -> each gives ERR: rvalid=1, err=1, no dm/tc strobe.
- m0 store 0x0000_00ff to 0x0000_7f14 -> tc2_we=1 one cycle, tc_addr=2'b01, tc1_we stays 0; reset asserted during ACC of a second access -> no rvalid afterward, FSM in IDLE.
- With DM_BUS_PERF_EN: 3 conflicting IDLE cycles plus 2 errors -> perf_conflict=3, perf_err=2.
